pipeline_riscv_core: RTL and testbench

Five-stage in-order RV32I-subset pipelined processor core (IF, ID, EX, MEM, WB) with internal instruction and data memories. It is the top-level compute block of the design. Its only ports are clock and reset; results are checked through its register file and data memory. Hazards are handled in hardware by forwarding, load-use stalling and branch flushing, so any program in the supported subset runs correctly without NOP padding.

---
 rtl/pipeline_riscv_core.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_pipeline_riscv_core.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_riscv_core.sv
// Five-stage in-order RV32I-subset core (IF/ID/EX/MEM/WB) with internal instruction and data memories.
// Hazards are resolved in hardware: EX operand forwarding, load-use stall, EX-stage redirect with flush.
module pipeline_riscv_core #(
    parameter int unsigned IMEM_DEPTH = 64,
    parameter int unsigned DMEM_DEPTH = 64,
    parameter string       IMEM_INIT  = "program.hex"
) (
    input logic clk,
    input logic rst
);
    localparam int unsigned IAW = $clog2(IMEM_DEPTH);
    localparam int unsigned DAW = $clog2(DMEM_DEPTH);

    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;

    typedef enum logic [2:0] {
        AluAdd, AluSub, AluAnd, AluOr, AluXor, AluSll, AluSrl, AluSlt
    } alu_op_e;

    typedef struct packed {
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    beq;
        logic    bne;
        logic    jal;
        logic    use_imm;
        alu_op_e alu_op;
    } ctrl_t;

    typedef struct packed {
        ctrl_t       ctrl;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
    } idex_t;

    typedef struct packed {
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic [4:0]  rd;
        logic [31:0] result;
        logic [31:0] store_data;
    } exmem_t;

    typedef struct packed {
        logic        reg_write;
        logic [4:0]  rd;
        logic [31:0] data;
    } memwb_t;

    logic [31:0] imem [IMEM_DEPTH];
    logic [31:0] dmem [DMEM_DEPTH];
    logic [31:0] regs [32];

    logic [31:0] pc_q;
    logic [31:0] ifid_instr_q, ifid_pc_q;
    idex_t       idex_q, idex_d;
    exmem_t      exmem_q, exmem_d;
    memwb_t      memwb_q, memwb_d;

    logic        stall, load_use, redirect;
    logic [31:0] ex_target;

    // ---------------- ID ----------------
    logic [6:0]  id_opcode, id_funct7;
    logic [2:0]  id_funct3;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [31:0] imm_i, imm_s, imm_b, imm_j, id_imm;
    logic [31:0] id_rs1_val, id_rs2_val;
    ctrl_t       id_ctrl;
    logic        legal, use_rs1, use_rs2;
    logic        wb_we;

    assign id_opcode = ifid_instr_q[6:0];
    assign id_rd     = ifid_instr_q[11:7];
    assign id_funct3 = ifid_instr_q[14:12];
    assign id_rs1    = ifid_instr_q[19:15];
    assign id_rs2    = ifid_instr_q[24:20];
    assign id_funct7 = ifid_instr_q[31:25];

    assign imm_i = {{20{ifid_instr_q[31]}}, ifid_instr_q[31:20]};
    assign imm_s = {{20{ifid_instr_q[31]}}, ifid_instr_q[31:25], ifid_instr_q[11:7]};
    assign imm_b = {{19{ifid_instr_q[31]}}, ifid_instr_q[31], ifid_instr_q[7],
                    ifid_instr_q[30:25], ifid_instr_q[11:8], 1'b0};
    assign imm_j = {{11{ifid_instr_q[31]}}, ifid_instr_q[31], ifid_instr_q[19:12],
                    ifid_instr_q[20], ifid_instr_q[30:21], 1'b0};

    always_comb begin
        id_ctrl = '0;
        legal   = 1'b1;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        id_imm  = imm_i;
        case (id_opcode)
            OpReg: begin
                id_ctrl.reg_write = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                case (id_funct3)
                    3'b000:  id_ctrl.alu_op = id_funct7[5] ? AluSub : AluAdd;
                    3'b001:  id_ctrl.alu_op = AluSll;
                    3'b010:  id_ctrl.alu_op = AluSlt;
                    3'b100:  id_ctrl.alu_op = AluXor;
                    3'b101:  id_ctrl.alu_op = AluSrl;
                    3'b110:  id_ctrl.alu_op = AluOr;
                    3'b111:  id_ctrl.alu_op = AluAnd;
                    default: legal = 1'b0;
                endcase
                if (id_funct7 != 7'b0000000 && !(id_funct7 == 7'b0100000 && id_funct3 == 3'b000))
                    legal = 1'b0;
            end
            OpImm: begin
                id_ctrl.reg_write = 1'b1;
                id_ctrl.use_imm   = 1'b1;
                use_rs1 = 1'b1;
                case (id_funct3)
                    3'b000:  id_ctrl.alu_op = AluAdd;
                    3'b010:  id_ctrl.alu_op = AluSlt;
                    3'b100:  id_ctrl.alu_op = AluXor;
                    3'b110:  id_ctrl.alu_op = AluOr;
                    3'b111:  id_ctrl.alu_op = AluAnd;
                    default: legal = 1'b0;
                endcase
            end
            OpLoad: begin
                id_ctrl.reg_write = 1'b1;
                id_ctrl.mem_read  = 1'b1;
                id_ctrl.use_imm   = 1'b1;
                use_rs1 = 1'b1;
                legal   = (id_funct3 == 3'b010);
            end
            OpStore: begin
                id_ctrl.mem_write = 1'b1;
                id_ctrl.use_imm   = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                id_imm  = imm_s;
                legal   = (id_funct3 == 3'b010);
            end
            OpBranch: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                id_imm  = imm_b;
                case (id_funct3)
                    3'b000:  id_ctrl.beq = 1'b1;
                    3'b001:  id_ctrl.bne = 1'b1;
                    default: legal = 1'b0;
                endcase
            end
            OpJal: begin
                id_ctrl.reg_write = 1'b1;
                id_ctrl.jal       = 1'b1;
                id_imm = imm_j;
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            id_ctrl = '0;
            use_rs1 = 1'b0;
            use_rs2 = 1'b0;
        end
    end

    // Write-through: a same-cycle WB write is visible to the ID read.
    assign wb_we      = memwb_q.reg_write && (memwb_q.rd != 5'd0);
    assign id_rs1_val = (id_rs1 == 5'd0) ? 32'd0 :
                        (wb_we && memwb_q.rd == id_rs1) ? memwb_q.data : regs[id_rs1];
    assign id_rs2_val = (id_rs2 == 5'd0) ? 32'd0 :
                        (wb_we && memwb_q.rd == id_rs2) ? memwb_q.data : regs[id_rs2];

    always_comb begin
        idex_d         = '0;
        idex_d.ctrl    = id_ctrl;
        idex_d.pc      = ifid_pc_q;
        idex_d.rs1     = use_rs1 ? id_rs1 : 5'd0;
        idex_d.rs2     = use_rs2 ? id_rs2 : 5'd0;
        idex_d.rd      = id_ctrl.reg_write ? id_rd : 5'd0;
        idex_d.rs1_val = id_rs1_val;
        idex_d.rs2_val = id_rs2_val;
        idex_d.imm     = id_imm;
    end

    assign load_use = idex_q.ctrl.mem_read && (idex_q.rd != 5'd0) &&
                      ((use_rs1 && idex_q.rd == id_rs1) || (use_rs2 && idex_q.rd == id_rs2));
    assign stall    = load_use && !redirect;

    // ---------------- EX ----------------
    logic [31:0] fwd_a, fwd_b, alu_b, alu_out;
    logic        exmem_fwd_ok;

    assign exmem_fwd_ok = exmem_q.reg_write && (exmem_q.rd != 5'd0);

    assign fwd_a = (exmem_fwd_ok && exmem_q.rd == idex_q.rs1) ? exmem_q.result :
                   (wb_we && memwb_q.rd == idex_q.rs1) ? memwb_q.data : idex_q.rs1_val;
    assign fwd_b = (exmem_fwd_ok && exmem_q.rd == idex_q.rs2) ? exmem_q.result :
                   (wb_we && memwb_q.rd == idex_q.rs2) ? memwb_q.data : idex_q.rs2_val;
    assign alu_b = idex_q.ctrl.use_imm ? idex_q.imm : fwd_b;

    always_comb begin
        alu_out = 32'd0;
        unique case (idex_q.ctrl.alu_op)
            AluAdd: alu_out = fwd_a + alu_b;
            AluSub: alu_out = fwd_a - alu_b;
            AluAnd: alu_out = fwd_a & alu_b;
            AluOr:  alu_out = fwd_a | alu_b;
            AluXor: alu_out = fwd_a ^ alu_b;
            AluSll: alu_out = fwd_a << alu_b[4:0];
            AluSrl: alu_out = fwd_a >> alu_b[4:0];
            AluSlt: alu_out = {31'd0, $signed(fwd_a) < $signed(alu_b)};
        endcase
    end

    assign ex_target = idex_q.pc + idex_q.imm;
    assign redirect  = idex_q.ctrl.jal || (idex_q.ctrl.beq && fwd_a == fwd_b) ||
                       (idex_q.ctrl.bne && fwd_a != fwd_b);

    always_comb begin
        exmem_d            = '0;
        exmem_d.reg_write  = idex_q.ctrl.reg_write;
        exmem_d.mem_read   = idex_q.ctrl.mem_read;
        exmem_d.mem_write  = idex_q.ctrl.mem_write;
        exmem_d.rd         = idex_q.rd;
        exmem_d.result     = idex_q.ctrl.jal ? idex_q.pc + 32'd4 : alu_out;
        exmem_d.store_data = fwd_b;
    end

    // ---------------- MEM ----------------
    logic [DAW-1:0] dmem_addr;
    assign dmem_addr = exmem_q.result[DAW+1:2];

    always_comb begin
        memwb_d           = '0;
        memwb_d.reg_write = exmem_q.reg_write;
        memwb_d.rd        = exmem_q.rd;
        memwb_d.data      = exmem_q.mem_read ? dmem[dmem_addr] : exmem_q.result;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DMEM_DEPTH); i++) dmem[i] <= 32'd0;
        end else if (exmem_q.mem_write) begin
            dmem[dmem_addr] <= exmem_q.store_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
        end else if (wb_we) begin
            regs[memwb_q.rd] <= memwb_q.data;
        end
    end

    // ---------------- Pipeline registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q         <= 32'd0;
            ifid_instr_q <= 32'd0;
            ifid_pc_q    <= 32'd0;
            idex_q       <= '0;
            exmem_q      <= '0;
            memwb_q      <= '0;
        end else begin
            if (redirect) begin
                pc_q         <= ex_target;
                ifid_instr_q <= 32'd0;
                ifid_pc_q    <= 32'd0;
            end else if (!stall) begin
                pc_q         <= pc_q + 32'd4;
                ifid_instr_q <= imem[pc_q[IAW+1:2]];
                ifid_pc_q    <= pc_q;
            end
            idex_q  <= (redirect || stall) ? '0 : idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
        end
    end

endmodule

// File: tb/tb_pipeline_riscv_core.sv
// Directed-program bench: expected writebacks are queued per program, a monitor checks each
// retiring register write (value, destination and cycle) against the queue.
module tb_pipeline_riscv_core;
    logic clk;
    logic rst;

    pipeline_riscv_core #(
        .IMEM_DEPTH(64),
        .DMEM_DEPTH(64),
        .IMEM_INIT ("")
    ) dut (
        .clk(clk),
        .rst(rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        int          wb_cyc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          tests = 0;
    int          fails = 0;
    int          cyc;
    int          stall_cnt;
    logic [31:0] prog [16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm[11:0], rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    localparam logic [6:0] OPI = 7'b0010011;
    localparam logic [6:0] OPL = 7'b0000011;

    // Cycle 1 is the first rising edge after reset release (the PC=0 fetch).
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (!rst && dut.stall) stall_cnt++;
    end

    // Monitor: a pending WB write lands on the next rising edge (cycle cyc+1).
    always @(negedge clk) begin
        if (!rst && dut.memwb_q.reg_write && dut.memwb_q.rd != 5'd0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_wb", {27'd0, dut.memwb_q.rd, dut.memwb_q.data}, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wb_rd_data", {27'd0, dut.memwb_q.rd, dut.memwb_q.data},
                    {27'd0, mon_e.rd, mon_e.data});
                chk("wb_cycle", 64'(cyc + 1), 64'(mon_e.wb_cyc));
            end
        end
    end

    task automatic push(input logic [4:0] rd, input logic [31:0] data, input int c);
        exp_t e;
        e.rd     = rd;
        e.data   = data;
        e.wb_cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 16; i++) prog[i] = 32'h0;
    endtask

    // Hold reset, load the program and drop stale expectations.
    task automatic load_prog();
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 64; i++) dut.imem[i] = (i < 16) ? prog[i] : 32'h0;
        exp_q.delete();
        stall_cnt = 0;
    endtask

    task automatic run_prog(input string name);
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        chk({name, "_drain"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic chk_reset_state(input string name);
        int nz;
        #1;
        nz = 0;
        for (int i = 0; i < 32; i++) if (dut.regs[i] != 32'd0) nz++;
        chk({name, "_pc"}, {32'd0, dut.pc_q}, 64'd0);
        chk({name, "_regs_nonzero"}, 64'(nz), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        stall_cnt = 0;
        repeat (2) @(negedge clk);
        chk_reset_state("reset");

        // ALU chain with back-to-back dependencies
        clear_prog();
        prog[0] = enc_i(32'd5, 5'd0, 3'b000, 5'd1, OPI);
        prog[1] = enc_i(32'd3, 5'd1, 3'b000, 5'd2, OPI);
        prog[2] = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);
        prog[3] = enc_r(7'h20, 5'd1, 5'd3, 3'b000, 5'd4);
        load_prog();
        push(5'd1, 32'd5, 5); push(5'd2, 32'd8, 6); push(5'd3, 32'd13, 7); push(5'd4, 32'd8, 8);
        run_prog("alu");
        chk("alu_x4", {32'd0, dut.regs[4]}, 64'd8);
        chk("alu_stalls", 64'(stall_cnt), 64'd0);

        // Load-use stall, store data forwarded from EX/MEM
        clear_prog();
        prog[0] = enc_i(32'd42, 5'd0, 3'b000, 5'd1, OPI);
        prog[1] = enc_s(32'd8, 5'd1, 5'd0);
        prog[2] = enc_i(32'd8, 5'd0, 3'b010, 5'd2, OPL);
        prog[3] = enc_r(7'h00, 5'd2, 5'd2, 3'b000, 5'd3);
        load_prog();
        push(5'd1, 32'd42, 5); push(5'd2, 32'd42, 7); push(5'd3, 32'd84, 9);
        run_prog("ldu");
        chk("ldu_mem2", {32'd0, dut.dmem[2]}, 64'd42);
        chk("ldu_x3", {32'd0, dut.regs[3]}, 64'd84);
        chk("ldu_stalls", 64'(stall_cnt), 64'd1);

        // Taken beq flushes the two younger instructions
        clear_prog();
        prog[0] = enc_i(32'd1, 5'd0, 3'b000, 5'd1, OPI);
        prog[1] = enc_b(32'd12, 5'd1, 5'd1, 3'b000);
        prog[2] = enc_i(32'd99, 5'd0, 3'b000, 5'd5, OPI);
        prog[3] = enc_i(32'd99, 5'd0, 3'b000, 5'd6, OPI);
        prog[4] = enc_i(32'd7, 5'd0, 3'b000, 5'd7, OPI);
        load_prog();
        #1;
        chk("rst_dmem_clear", {32'd0, dut.dmem[2]}, 64'd0);
        push(5'd1, 32'd1, 5); push(5'd7, 32'd7, 9);
        run_prog("beq");
        chk("beq_x5", {32'd0, dut.regs[5]}, 64'd0);
        chk("beq_x6", {32'd0, dut.regs[6]}, 64'd0);
        chk("beq_x7", {32'd0, dut.regs[7]}, 64'd7);

        // Not-taken bne then jal over PC 8
        clear_prog();
        prog[0] = enc_b(32'd8, 5'd0, 5'd0, 3'b001);
        prog[1] = enc_j(32'd8, 5'd1);
        prog[2] = enc_i(32'd55, 5'd0, 3'b000, 5'd2, OPI);
        prog[3] = enc_i(32'd33, 5'd0, 3'b000, 5'd3, OPI);
        load_prog();
        push(5'd1, 32'd8, 6); push(5'd3, 32'd33, 9);
        run_prog("jal");
        chk("jal_x2", {32'd0, dut.regs[2]}, 64'd0);
        chk("jal_x3", {32'd0, dut.regs[3]}, 64'd33);

        // x0 immutability, signed slti, srl by forwarded amount
        clear_prog();
        prog[0] = enc_i(32'd5, 5'd0, 3'b000, 5'd0, OPI);
        prog[1] = enc_i(32'hFFFF_FFFF, 5'd0, 3'b000, 5'd1, OPI);
        prog[2] = enc_i(32'd0, 5'd1, 3'b010, 5'd2, OPI);
        prog[3] = enc_r(7'h00, 5'd2, 5'd1, 3'b101, 5'd3);
        load_prog();
        push(5'd1, 32'hFFFF_FFFF, 6); push(5'd2, 32'd1, 7); push(5'd3, 32'h7FFF_FFFF, 8);
        run_prog("sgn");
        chk("sgn_x0", {32'd0, dut.regs[0]}, 64'd0);
        chk("sgn_x3", {32'd0, dut.regs[3]}, 64'h7FFF_FFFF);

        // Reset mid-flight during the ALU chain, then rerun
        clear_prog();
        prog[0] = enc_i(32'd5, 5'd0, 3'b000, 5'd1, OPI);
        prog[1] = enc_i(32'd3, 5'd1, 3'b000, 5'd2, OPI);
        prog[2] = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);
        prog[3] = enc_r(7'h20, 5'd1, 5'd3, 3'b000, 5'd4);
        load_prog();
        push(5'd1, 32'd5, 5); push(5'd2, 32'd8, 6);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 50 && cyc < 6; i++) @(negedge clk);
        chk("midrst_reached", 64'(cyc), 64'd6);
        rst = 1'b1;
        chk_reset_state("midrst");
        @(negedge clk);
        @(negedge clk);
        chk("midrst_x3_held", {32'd0, dut.regs[3]}, 64'd0);
        chk("midrst_drain", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        push(5'd1, 32'd5, 5); push(5'd2, 32'd8, 6); push(5'd3, 32'd13, 7); push(5'd4, 32'd8, 8);
        run_prog("rerun");
        chk("rerun_x1", {32'd0, dut.regs[1]}, 64'd5);
        chk("rerun_x2", {32'd0, dut.regs[2]}, 64'd8);
        chk("rerun_x3", {32'd0, dut.regs[3]}, 64'd13);
        chk("rerun_x4", {32'd0, dut.regs[4]}, 64'd8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
